// File: rtl/vga_fifo_fetch.sv
// vga_fifo_fetch: burst-fetches framebuffer words over the shared bus into a
// small FIFO and unpacks them into pixels for color_gen, one pixel per
// output_valid cycle. A vsync_L fall restarts the frame from BASE_ADDR.
//
// Handshake: bus_req rises with a stable bus_out/ctrl_out and stays high until
// bus_ack is seen; from the following cycle every cycle with bus_wait=0
// carries one beat on bus_in, and bus_req falls on the edge that captures the
// last of BURST_LEN beats. output_valid has no back-pressure: each high cycle
// consumes one pixel if one is buffered, otherwise it records an underflow.
module vga_fifo_fetch #(
  parameter int COLOR_DEPTH = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int CTRL_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int BURST_LEN   = 4,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk25MHz,
  input  logic                   reset_L,
  input  logic                   vsync_L,
  input  logic                   output_valid,
  output logic [COLOR_DEPTH-1:0] pixel,
  output logic                   underflow,
  output logic                   bus_req,
  input  logic                   bus_ack,
  input  logic                   bus_wait,
  input  logic [BUS_WIDTH-1:0]   bus_in,
  output logic [BUS_WIDTH-1:0]   bus_out,
  output logic [CTRL_WIDTH-1:0]  ctrl_out,
  output logic [1:0]             fsm_state
);

  localparam int PPW = BUS_WIDTH / COLOR_DEPTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BEW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [BUS_WIDTH-1:0]  TOTAL      = BUS_WIDTH'(H_ACTIVE * V_ACTIVE / PPW);
  localparam logic [BUS_WIDTH-1:0]  BASE       = BUS_WIDTH'(BASE_ADDR);
  localparam logic [BUS_WIDTH-1:0]  BURST_W    = BUS_WIDTH'(BURST_LEN);
  localparam logic [AW:0]           REQ_LIMIT  = (AW+1)'(FIFO_DEPTH - BURST_LEN);
  localparam logic [AW:0]           FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(PPW - 1);
  localparam logic [BEW-1:0]        BEAT_LAST  = BEW'(BURST_LEN - 1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_CONST = CTRL_WIDTH'((BURST_LEN - 1) << 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t               state;
  logic                 vsync_q;
  logic                 flush_pend;
  logic [BUS_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0] words_left;
  logic [BEW-1:0]       beat;

  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [IW-1:0]        idx;
  logic [BUS_WIDTH-1:0] head;

  logic vs_fall;
  logic push;
  logic empty;
  logic consume;
  logic pop;

  assign vs_fall   = vsync_q & ~vsync_L;
  // Beats of a burst overtaken by a frame restart are still accepted on the
  // bus but never enter the FIFO.
  assign push      = (state == XFER) && !bus_wait && !flush_pend;
  assign empty     = (count == '0);
  assign consume   = output_valid && !empty;
  assign pop       = consume && (idx == IDX_LAST);
  assign head      = mem[rd_ptr];
  assign ctrl_out  = CTRL_CONST;
  assign fsm_state = state;

  // Detect the vsync_L fall and remember it until the FSM performs the flush.
  always_ff @(posedge clk25MHz or negedge reset_L) begin
    if (!reset_L) begin
      vsync_q    <= 1'b1;
      flush_pend <= 1'b0;
    end else begin
      vsync_q <= vsync_L;
      if (vs_fall)
        flush_pend <= 1'b1;
      else if (state == FLUSH)
        flush_pend <= 1'b0;
    end
  end

  // Fetch FSM: request a burst whenever a whole burst fits, never truncate one.
  always_ff @(posedge clk25MHz or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      addr       <= BASE;
      words_left <= TOTAL;
      beat       <= '0;
      bus_req    <= 1'b0;
      bus_out    <= BASE;
    end else begin
      case (state)
        IDLE: begin
          if (flush_pend) begin
            state <= FLUSH;
          end else if (words_left != '0 && count <= REQ_LIMIT) begin
            bus_req <= 1'b1;
            bus_out <= addr;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            beat  <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (!bus_wait) begin
            if (beat == BEAT_LAST) begin
              bus_req    <= 1'b0;
              addr       <= addr + BURST_W;
              words_left <= (words_left > BURST_W) ? (words_left - BURST_W) : '0;
              state      <= IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        FLUSH: begin
          addr       <= BASE;
          words_left <= TOTAL;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk25MHz) begin
    if (push)
      mem[wr_ptr] <= bus_in;
  end

  // FIFO pointers and occupancy; a flush discards everything buffered.
  always_ff @(posedge clk25MHz or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (state == FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pixel index within the head word and the sticky underflow flag.
  always_ff @(posedge clk25MHz or negedge reset_L) begin
    if (!reset_L) begin
      idx       <= '0;
      underflow <= 1'b0;
    end else if (state == FLUSH) begin
      idx       <= '0;
      underflow <= 1'b0;
    end else begin
      if (consume)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (output_valid && empty)
        underflow <= 1'b1;
    end
  end

  // Select the current field of the head word; zero whenever nothing is buffered.
  always_comb begin
    pixel = '0;
    if (!empty)
      pixel = head[32'(idx) * COLOR_DEPTH +: COLOR_DEPTH];
  end

`ifndef SYNTHESIS
  // Requests are only issued with BURST_LEN words free, so this never fires.
  always_ff @(posedge clk25MHz) begin
    if (reset_L)
      assert (!(push && count == FULL_CNT));
  end
`endif

endmodule
